ro_heater_pwm: RTL and testbench
================================

# ro_heater_pwm

Parametrised ring-oscillator heater for thermal/XADC experiments in a reconfigurable partition. It provides NUM_BANKS independently maskable oscillator banks, all gated by a shared PWM duty cycle. The duty cycle ramps at a programmable rate toward its target (soft start and soft stop), so supply current steps stay bounded. Control and status use the same two-register bus interface as the other partition modules: reg_0 is written by the processor, reg_1 is read back.

## Interface
- BUS_WIDTH, 32, register width; fixed at 32.
- NUM_BANKS, 8, number of oscillator banks; range 1..15.
- RINGS_PER_BANK, 16, rings per bank.
- LOOP_LEN, 128, nodes per ring (one AND plus LOOP_LEN-1 inverters); must be even.
- PWM_BITS, 8, duty resolution; range 1..8. PWM period is 2^PWM_BITS cycles.
- RAMP_DIV, 1024, cycles per ramp step; must be ≥1.
- Clk  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- reg_0  in  BUS_WIDTH  control word: [0] EN; [NUM_BANKS:1] bank mask; [16+PWM_BITS-1:16] duty target; [31] CLR, which clears the on-period counter. All other bits are ignored.
- reg_1  out  BUS_WIDTH  status word: [1:0] state; [15:8] duty_cur, zero-extended; [31:16] on-period counter. All other bits read 0.

## Operation
- States: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.
- Effective target:
  - It is the duty target when EN=1 and the mask is non-zero.
  - Otherwise it is 0.
- Ramp prescaler:
  - Counts 0..RAMP_DIV-1 while not in IDLE, and is held at 0 in IDLE.
  - ramp_tick is asserted when the prescaler equals RAMP_DIV-1.
- State transitions:
  - IDLE→RAMP_UP when the effective target is greater than 0.
  - RAMP_UP: duty_cur+=1 on each ramp_tick. Goes to RUN when duty_cur equals the target. Goes to RAMP_DOWN if the target falls below duty_cur.
  - RAMP_DOWN: duty_cur-=1 on each ramp_tick. Goes to IDLE when duty_cur reaches 0 and the target is 0. Goes to RUN when duty_cur equals a non-zero target. Goes to RAMP_UP if the target rises above duty_cur.
  - RUN: goes to RAMP_UP or RAMP_DOWN as soon as the target differs from duty_cur.
- duty_cur never wraps. It saturates at the target in the direction of travel.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter.
  - duty_lat loads duty_cur when pwm_cnt==0, so duty is glitch-free within a period.
  - Gate equation: bank_on[b] = (pwm_cnt < duty_lat) & mask[b] & (state≠IDLE).
  - bank_on is registered. The mask is sampled every cycle, so a bank drops out one cycle after its mask bit clears.
- Duty limits: duty_lat = 2^PWM_BITS-1 gives (2^PWM_BITS-1)/2^PWM_BITS on-time; 100% is never reached. duty_lat = 0 gives fully off.
- On-period counter:
  - 16-bit, saturating at 0xFFFF.
  - Increments at each pwm_cnt wrap when any bank_on was high during the period just ended.
  - CLR=1 holds it at 0. CLR has priority over increment.
- Each ring is AND(bank_on[b], last node) feeding LOOP_LEN-1 inverters. All ring nets must survive synthesis (KEEP).

## Timing
- Reset values while Reset_n=0 at a rising edge:
  - state=IDLE; duty_cur=0; duty_lat=0; pwm_cnt=0; prescaler=0.
  - bank_on=0; counter=0; reg_1=0.
- Reset mid-ramp or mid-run kills all banks at the next edge, with no ramp-down.
- reg_1 is registered and reflects the internal state with 1-cycle latency.
- Control-to-gate latency: a reg_0 change is sampled at edge N. The state changes at N. The first duty step appears at the first ramp_tick after N. A new duty takes effect at the next pwm_cnt==0, and bank_on follows one cycle later.
- EN deasserting mid-ramp reverses into RAMP_DOWN from the current duty_cur, with no jump.
- A target change coinciding with ramp_tick: the step follows the direction computed from the new target at that same edge.

## Structure
- Package ro_heater_pkg holds:
  - the state encoding;
  - reg_0 and reg_1 field positions: EN_BIT=0, MASK_LSB=1, DUTY_LSB=16, CLR_BIT=31, STATE_LSB=0, DUTY_CUR_LSB=8, CNT_LSB=16.
- Sub-module ro_ring (ports: en, LOOP_LEN parameter) contains one gated ring with KEEP attributes. The top level instantiates NUM_BANKS×RINGS_PER_BANK of them.
- Simulation: ro_ring is replaced by a stub that ties the loop off. The bench observes bank_on through hierarchy.

## Test plan
Parameters for all scenarios: PWM_BITS=4, RAMP_DIV=4, NUM_BANKS=4.
- Soft start: reset, then reg_0={duty=8, mask=4'b1111, EN=1}.
  - duty_cur steps 1..8, one step every 4 cycles, then state=RUN.
  - bank_on is high for 8 of every 16 cycles.
- Soft stop: from RUN at duty 8, clear EN.
  - state goes RAMP_DOWN, duty_cur decrements to 0 over 32 cycles, then IDLE; bank_on stays 0.
- Mask and boundary duty: duty=15, mask=4'b0101.
  - Only banks 0 and 2 toggle, each on 15/16 cycles.
  - Clearing mask bit 2 drops bank 2 within 1 cycle.
- Reversal: raise the target from 3 to 10, then drop it to 5 while duty_cur=7.
  - State goes RAMP_UP then RAMP_DOWN, and duty_cur settles at 5 (RUN) with no wrap or skip.
- Counter: run at duty 1 for 20 periods.
  - reg_1[31:16]=20.
  - Asserting CLR gives 0 next cycle; after a preload the counter saturates at 0xFFFF.
- Reset mid-ramp: drive Reset_n=0 during RAMP_UP.
  - reg_1=0 and all bank_on=0 after 1 edge; operation resumes cleanly once EN is re-asserted.

Source files
------------

// File: rtl/ro_heater_pkg.sv
// Shared definitions for the ring-oscillator heater: state encoding and register field positions.
package ro_heater_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRampUp   = 2'd1,
        StRun      = 2'd2,
        StRampDown = 2'd3
    } heater_state_e;

    // reg_0 (control) field positions
    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned MASK_LSB = 1;
    localparam int unsigned DUTY_LSB = 16;
    localparam int unsigned CLR_BIT  = 31;

    // reg_1 (status) field positions
    localparam int unsigned STATE_LSB    = 0;
    localparam int unsigned DUTY_CUR_LSB = 8;
    localparam int unsigned CNT_LSB      = 16;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/ro_heater_pwm_ring.sv
// One gated ring oscillator: AND(en, last node) followed by LOOP_LEN-1 inverters.
// SIM_STUB ties the loop off so zero-delay simulators do not spin on it.
module ro_ring #(
    parameter int unsigned LOOP_LEN = 128,
    parameter bit          SIM_STUB = 1'b0
) (
    input logic en
);

    if (SIM_STUB) begin : g_stub
        logic unused_en;
        assign unused_en = en;
    end else begin : g_ring
        (* keep = "true", dont_touch = "true", allow_combinatorial_loops = "true" *)
        logic [LOOP_LEN-1:0] node;

        assign node[0] = en & node[LOOP_LEN-1];
        for (genvar i = 1; i < LOOP_LEN; i++) begin : g_inv
            assign node[i] = ~node[i-1];
        end
    end

endmodule

// File: rtl/ro_heater_pwm.sv
// Ring-oscillator heater: soft-ramped PWM duty gating NUM_BANKS maskable banks of rings,
// with a saturating count of PWM periods in which any bank was on.
module ro_heater_pwm
    import ro_heater_pkg::*;
#(
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned NUM_BANKS      = 8,
    parameter int unsigned RINGS_PER_BANK = 16,
    parameter int unsigned LOOP_LEN       = 128,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned RAMP_DIV       = 1024,
    parameter bit          SIM_STUB       = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [BUS_WIDTH-1:0] reg_0,
    output logic [BUS_WIDTH-1:0] reg_1
);

    localparam int unsigned        PRESC_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

    // Control decode
    logic                 ctrl_en;
    logic                 ctrl_clr;
    logic [NUM_BANKS-1:0] ctrl_mask;
    logic [PWM_BITS-1:0]  ctrl_duty;
    logic [PWM_BITS-1:0]  target;
    logic                 unused_reg_0;

    assign ctrl_en      = reg_0[EN_BIT];
    assign ctrl_clr     = reg_0[CLR_BIT];
    assign ctrl_mask    = reg_0[MASK_LSB +: NUM_BANKS];
    assign ctrl_duty    = reg_0[DUTY_LSB +: PWM_BITS];
    assign target       = (ctrl_en && (|ctrl_mask)) ? ctrl_duty : '0;
    assign unused_reg_0 = ^reg_0;

    // State
    heater_state_e         state_q, state_d;
    logic [PWM_BITS-1:0]   duty_cur_q, duty_cur_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0]   duty_lat_q, duty_lat_d;
    logic [NUM_BANKS-1:0]  bank_on_q, bank_on_d;
    logic                  any_on_q, any_on_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]  reg_1_q, reg_1_d;

    logic                  ramp_tick;
    logic                  pwm_wrap;
    logic                  period_on;
    logic [PWM_BITS-1:0]   duty_eff;

    assign ramp_tick = (presc_q == PRESC_MAX);
    assign pwm_wrap  = (pwm_cnt_q == PWM_MAX);

    // Ramp prescaler and duty/state FSM
    always_comb begin
        presc_d    = '0;
        duty_cur_d = duty_cur_q;
        state_d    = state_q;

        if (state_q != StIdle) begin
            presc_d = ramp_tick ? '0 : presc_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (target != '0) begin
                    state_d = StRampUp;
                end
            end
            StRampUp, StRun, StRampDown: begin
                // Step direction comes from the live target so a change on a tick edge
                // never overshoots; stepping toward the target also prevents wrapping.
                if (ramp_tick && (state_q != StRun)) begin
                    if (target > duty_cur_q) begin
                        duty_cur_d = duty_cur_q + 1'b1;
                    end else if (target < duty_cur_q) begin
                        duty_cur_d = duty_cur_q - 1'b1;
                    end
                end
                if (duty_cur_d == target) begin
                    state_d = (target == '0) ? StIdle : StRun;
                end else if (target > duty_cur_d) begin
                    state_d = StRampUp;
                end else begin
                    state_d = StRampDown;
                end
            end
        endcase
    end

    // PWM gate: the slot at pwm_cnt==0 already uses the duty being latched for this period.
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        duty_eff   = (pwm_cnt_q == '0) ? duty_cur_q : duty_lat_q;
        duty_lat_d = duty_eff;
        bank_on_d  = {NUM_BANKS{(pwm_cnt_q < duty_eff) && (state_q != StIdle)}} & ctrl_mask;
    end

    // On-period counter
    always_comb begin
        period_on = any_on_q | (|bank_on_d);
        any_on_d  = pwm_wrap ? 1'b0 : period_on;
        cnt_d     = cnt_q;
        if (ctrl_clr) begin
            cnt_d = '0;
        end else if (pwm_wrap && period_on && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        reg_1_d                            = '0;
        reg_1_d[STATE_LSB +: 2]            = state_q;
        reg_1_d[DUTY_CUR_LSB +: PWM_BITS]  = duty_cur_q;
        reg_1_d[CNT_LSB +: CNT_W]          = cnt_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            duty_cur_q <= '0;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            duty_lat_q <= '0;
            bank_on_q  <= '0;
            any_on_q   <= 1'b0;
            cnt_q      <= '0;
            reg_1_q    <= '0;
        end else begin
            state_q    <= state_d;
            duty_cur_q <= duty_cur_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_lat_q <= duty_lat_d;
            bank_on_q  <= bank_on_d;
            any_on_q   <= any_on_d;
            cnt_q      <= cnt_d;
            reg_1_q    <= reg_1_d;
        end
    end

    assign reg_1 = reg_1_q;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar r = 0; r < RINGS_PER_BANK; r++) begin : g_ring
            ro_ring #(
                .LOOP_LEN (LOOP_LEN),
                .SIM_STUB (SIM_STUB)
            ) u_ring (
                .en (bank_on_q[b])
            );
        end
    end

endmodule

// File: tb/tb_ro_heater_pwm.sv
// Directed bench for ro_heater_pwm with PWM_BITS=4, RAMP_DIV=4, NUM_BANKS=4.
// t counts rising edges since reset release; all expected values are hand-derived from t.
module tb_ro_heater_pwm;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] reg_0;
    logic [31:0] reg_1;

    int t;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    ro_heater_pwm #(
        .BUS_WIDTH      (32),
        .NUM_BANKS      (4),
        .RINGS_PER_BANK (2),
        .LOOP_LEN       (4),
        .PWM_BITS       (4),
        .RAMP_DIV       (4),
        .SIM_STUB       (1'b1)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .reg_0   (reg_0),
        .reg_1   (reg_1)
    );

    function automatic logic [31:0] ctrl(input logic en, input logic [3:0] mask,
                                         input logic [3:0] duty, input logic clr);
        logic [31:0] w;
        w        = '0;
        w[0]     = en;
        w[4:1]   = mask;
        w[19:16] = duty;
        w[31]    = clr;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, t);
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input logic [7:0] duty);
        check({tag, "_state"}, {30'd0, reg_1[1:0]}, {30'd0, st});
        check({tag, "_duty"}, {24'd0, reg_1[15:8]}, {24'd0, duty});
    endtask

    // Advance to the falling edge following rising edge number 'target'.
    task automatic goto(input int target);
        while (t < target) begin
            @(negedge Clk);
            t++;
        end
    endtask

    task automatic count_banks(input logic [3:0] pattern, output int hits, output int other);
        hits  = 0;
        other = 0;
        for (int i = 0; i < 16; i++) begin
            goto(t + 1);
            if (dut.bank_on_q == pattern) hits++;
            else if (dut.bank_on_q != 4'b0000) other++;
        end
    endtask

    initial begin
        int hits, other;

        Reset_n = 1'b0;
        reg_0   = '0;
        t       = -100;
        repeat (3) @(negedge Clk);

        // Reset state
        check("rst_reg_1", reg_1, 32'h0);
        check("rst_bank_on", {28'd0, dut.bank_on_q}, 32'h0);
        check("rst_pwm_cnt", {28'd0, dut.pwm_cnt_q}, 32'h0);
        check("rst_duty_lat", {28'd0, dut.duty_lat_q}, 32'h0);

        // Soft start: duty 8, all banks
        reg_0   = ctrl(1'b1, 4'b1111, 4'd8, 1'b0);
        Reset_n = 1'b1;
        t       = -1;
        goto(1);
        check_status("start_entry", 2'd1, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            goto(4 * k);
            check_status("start_pre", 2'd1, 8'(k - 1));
            goto(4 * k + 1);
            check("start_step", {24'd0, reg_1[15:8]}, k);
        end
        goto(33);
        check_status("start_run", 2'd2, 8'd8);
        check("start_rsvd", {26'd0, reg_1[7:2]}, 32'h0);
        goto(64);
        count_banks(4'b1111, hits, other);
        check("start_on_cycles", hits, 8);
        check("start_partial", other, 0);

        // Soft stop
        goto(83);
        reg_0 = ctrl(1'b0, 4'b1111, 4'd8, 1'b0);
        goto(85);
        check_status("stop_entry", 2'd3, 8'd8);
        goto(101);
        check_status("stop_mid", 2'd3, 8'd4);
        goto(116);
        check_status("stop_last", 2'd3, 8'd1);
        goto(117);
        check_status("stop_idle", 2'd0, 8'd0);
        goto(119);
        count_banks(4'b1111, hits, other);
        check("stop_banks", hits + other, 0);

        // On-period counter at duty 1, bank 0
        goto(136);
        reg_0 = ctrl(1'b1, 4'b0001, 4'd1, 1'b1);
        goto(142);
        check_status("cnt_run", 2'd2, 8'd1);
        check("cnt_held_clr", {16'd0, reg_1[31:16]}, 32'd0);
        goto(143);
        reg_0 = ctrl(1'b1, 4'b0001, 4'd1, 1'b0);
        goto(161);
        check("cnt_first", {16'd0, reg_1[31:16]}, 32'd1);
        goto(463);
        check("cnt_19", {16'd0, reg_1[31:16]}, 32'd19);
        goto(464);
        check("cnt_20", {16'd0, reg_1[31:16]}, 32'd20);
        goto(470);
        reg_0 = ctrl(1'b1, 4'b0001, 4'd1, 1'b1);
        goto(471);
        check("cnt_clr_int", {16'd0, dut.cnt_q}, 32'd0);
        goto(472);
        check("cnt_clr_reg", {16'd0, reg_1[31:16]}, 32'd0);
        reg_0 = ctrl(1'b1, 4'b0001, 4'd1, 1'b0);
        goto(474);
        force dut.cnt_q = 16'hFFFE;
        goto(475);
        release dut.cnt_q;
        goto(479);
        check("cnt_preload", {16'd0, reg_1[31:16]}, 32'h0000_FFFE);
        goto(481);
        check("cnt_top", {16'd0, reg_1[31:16]}, 32'h0000_FFFF);
        goto(500);
        check("cnt_saturate", {16'd0, reg_1[31:16]}, 32'h0000_FFFF);

        // Mask 0101 at the maximum duty
        reg_0 = ctrl(1'b1, 4'b0101, 4'd15, 1'b0);
        goto(558);
        check_status("mask_run", 2'd2, 8'd15);
        goto(575);
        count_banks(4'b0101, hits, other);
        check("mask_on_cycles", hits, 15);
        check("mask_other_banks", other, 0);
        goto(600);
        check("mask_before_drop", {28'd0, dut.bank_on_q}, 32'h5);
        reg_0 = ctrl(1'b1, 4'b0001, 4'd15, 1'b0);
        goto(601);
        check("mask_drop_bank2", {28'd0, dut.bank_on_q}, 32'h1);

        // Reversal: settle at 3, raise to 10, drop to 5 while at 7
        goto(604);
        reg_0 = ctrl(1'b1, 4'b1111, 4'd3, 1'b0);
        goto(654);
        check_status("rev_at3", 2'd2, 8'd3);
        goto(660);
        reg_0 = ctrl(1'b1, 4'b1111, 4'd10, 1'b0);
        goto(662);
        check_status("rev_up_entry", 2'd1, 8'd3);
        goto(678);
        check_status("rev_at7", 2'd1, 8'd7);
        reg_0 = ctrl(1'b1, 4'b1111, 4'd5, 1'b0);
        goto(680);
        check_status("rev_down_entry", 2'd3, 8'd7);
        goto(682);
        check_status("rev_down_step", 2'd3, 8'd6);
        goto(686);
        check_status("rev_settle", 2'd2, 8'd5);
        goto(700);
        check_status("rev_hold", 2'd2, 8'd5);

        // Reset mid-ramp
        reg_0 = ctrl(1'b1, 4'b1111, 4'd12, 1'b0);
        goto(710);
        check_status("rr_ramping", 2'd1, 8'd7);
        Reset_n = 1'b0;
        reg_0   = '0;
        goto(711);
        check("rr_reg_1", reg_1, 32'h0);
        check("rr_bank_on", {28'd0, dut.bank_on_q}, 32'h0);
        goto(712);
        Reset_n = 1'b1;
        goto(715);
        check("rr_idle", reg_1, 32'h0);
        goto(716);
        reg_0 = ctrl(1'b1, 4'b0011, 4'd2, 1'b0);
        goto(722);
        check_status("rr_step1", 2'd1, 8'd1);
        goto(726);
        check_status("rr_run", 2'd2, 8'd2);
        goto(739);
        count_banks(4'b0011, hits, other);
        check("rr_on_cycles", hits, 2);
        check("rr_other", other, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
